// File: rtl/uart_byte_rx.sv
// uart_byte_rx: UART byte receiver (8N1) with a 2-flop input synchronizer and a 4-entry receive FIFO.
// Optional macro UART_RX_PARITY_EN switches the frame to 8E1, checking even parity before the stop bit.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       uartRxRst,
  input  logic       uartRx,
  input  logic       rxReady,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameErr,
  output logic       overrun,
  output logic       rxBusy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned PTR_W        = 2;
  localparam int unsigned FCNT_W       = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERRWAIT} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERRWAIT} state_t;
`endif

  state_t              state, state_n;
  logic                sync1, rxS, rx_prev;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [DATA_W-1:0]   shift, shift_n;
  logic                frame_err_n;
  logic                push_c;
`ifdef UART_RX_PARITY_EN
  logic                par_err, par_err_n;
`endif

  // Input synchronizer; rx_prev holds the previous synchronized level for edge detection.
  always_ff @(posedge clk or posedge uartRxRst) begin
    if (uartRxRst) begin
      sync1   <= 1'b1;
      rxS     <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= uartRx;
      rxS     <= sync1;
      rx_prev <= rxS;
    end
  end

  // Receiver state and bit-timing registers.
  always_ff @(posedge clk or posedge uartRxRst) begin
    if (uartRxRst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      frameErr <= 1'b0;
      rxBusy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      frameErr <= frame_err_n;
      rxBusy   <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_err  <= par_err_n;
`endif
    end
  end

  // Next-state: samples land mid-bit, one bit period apart after the mid-start sample.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    frame_err_n = 1'b0;
    push_c      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n   = par_err;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rxS) begin
          state_n   = START;
          bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
          par_err_n = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_n   = '0;
          state_n = rxS ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          shift_n   = {rxS, shift[DATA_W-1:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n     = '0;
          par_err_n = (rxS != ^shift);
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          if (rxS && !par_err) begin
`else
          if (rxS) begin
`endif
            push_c  = 1'b1;
            state_n = IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ERRWAIT;
          end
        end
      end
      ERRWAIT: begin
        cnt_n = '0;
        if (rxS) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] count, count_n;
  logic              pop_c, push_ok_c;

  // A full FIFO still takes a push when the head is popped in the same cycle.
  assign pop_c     = rxValid & rxReady;
  assign push_ok_c = push_c & ((count < FCNT_W'(DEPTH)) | pop_c);
  assign count_n   = count + FCNT_W'(push_ok_c) - FCNT_W'(pop_c);
  assign rxData    = mem[rd_ptr];

  always_ff @(posedge clk or posedge uartRxRst) begin
    if (uartRxRst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_n;
      rxValid <= (count_n != '0);
      if (push_c && !push_ok_c) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: directed frame table, multi-cycle corner sequences and random frames
// checked every cycle against a byte-queue model of the receive FIFO.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 1600000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  // Cycles from driving the start edge to the byte becoming visible at the FIFO head.
  localparam int LAT = int'(2 + CPB / 2 + (NBITS - 1) * CPB + 1);

  logic       clk, rst, rx, ready;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .uartRxRst(rst), .uartRx(rx), .rxReady(ready),
    .rxData(data), .rxValid(valid), .frameErr(ferr), .overrun(ovr), .rxBusy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors, checks, cyc, pops, ferr_seen;
  logic [7:0] mq[$];
  bit         movr;
  int         pend_edge;
  bit         pend_good;
  logic [7:0] pend_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update the model across the edge, then compare the DUT just after it.
  task automatic tick();
    bit pop, exp_fe;
    logic [7:0] tmp;
    pop = (ready == 1'b1) && (mq.size() != 0);
    @(posedge clk);
    cyc++;
    if (pop) begin
      tmp = mq.pop_front();
      pops++;
    end
    exp_fe = 1'b0;
    if (cyc == pend_edge) begin
      if (pend_good) begin
        if (mq.size() < 4) mq.push_back(pend_byte);
        else movr = 1'b1;
      end else exp_fe = 1'b1;
      pend_edge = -1;
    end
    #1;
    if (!rst) begin
      check("rxValid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("rxData", 32'(data), 32'(mq[0]));
      check("frameErr", 32'(ferr), 32'(exp_fe));
      check("overrun", 32'(ovr), 32'(movr));
      if (ferr) ferr_seen++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_rand(input int n);
    for (int i = 0; i < n; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    rx  = 1'b1;
    mq.delete();
    movr      = 1'b0;
    pend_edge = -1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst rxValid", 32'(valid), 32'd0);
      check("rst rxData", 32'(data), 32'd0);
      check("rst frameErr", 32'(ferr), 32'd0);
      check("rst overrun", 32'(ovr), 32'd0);
      check("rst rxBusy", 32'(busy), 32'd0);
      @(posedge clk);
      cyc++;
    end
    #1;
    rst = 1'b0;
  endtask

  // Drive one frame (possibly cut short after ncyc line cycles); called just after a clock edge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input int ncyc);
    logic [10:0] fr;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = b;
`ifdef UART_RX_PARITY_EN
    fr[9] = par_ok ? ^b : ~(^b);
    pend_good = stop_ok && par_ok;
`else
    pend_good = stop_ok;
`endif
    fr[NBITS-1] = stop_ok;
    pend_byte = b;
    pend_edge = cyc + LAT;
    for (int i = 0; i < ncyc; i++) begin
      rx = fr[i / int'(CPB)];
      tick();
    end
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    bit         ready;
    int         exp_ferr;
    int         exp_pops;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] burst[5];
  logic [7:0] drain_exp[4];
  int         s;
  logic [7:0] rb;
  bit         rs, rp;

  initial begin
    errors = 0; checks = 0; cyc = 0; pops = 0; ferr_seen = 0;
    movr = 1'b0; pend_edge = -1; pend_good = 1'b0; pend_byte = '0;
    rx = 1'b1; ready = 1'b0; rst = 1'b1;

    vecs.push_back('{data: 8'hA5, stop_ok: 1, par_ok: 1, ready: 1, exp_ferr: 0, exp_pops: 1});
    vecs.push_back('{data: 8'h55, stop_ok: 0, par_ok: 1, ready: 1, exp_ferr: 1, exp_pops: 0});
    vecs.push_back('{data: 8'h12, stop_ok: 1, par_ok: 1, ready: 1, exp_ferr: 0, exp_pops: 1});
    vecs.push_back('{data: 8'h00, stop_ok: 1, par_ok: 1, ready: 1, exp_ferr: 0, exp_pops: 1});
    vecs.push_back('{data: 8'hFF, stop_ok: 1, par_ok: 1, ready: 1, exp_ferr: 0, exp_pops: 1});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{data: 8'h07, stop_ok: 1, par_ok: 1, ready: 1, exp_ferr: 0, exp_pops: 1});
    vecs.push_back('{data: 8'h07, stop_ok: 1, par_ok: 0, ready: 1, exp_ferr: 1, exp_pops: 0});
`endif
    burst     = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E};
    drain_exp = '{8'h00, 8'hFF, 8'h3C, 8'h81};

    @(posedge clk);
    cyc++;
    do_reset(4);
    idle(8);
    check("idle rxBusy", 32'(busy), 32'd0);

    // Directed frame table.
    foreach (vecs[k]) begin
      ready = vecs[k].ready;
      pops = 0;
      ferr_seen = 0;
      send_frame(vecs[k].data, vecs[k].stop_ok, vecs[k].par_ok, int'(NBITS * CPB));
      idle(32);
      check($sformatf("vec%0d frameErr pulses", k), 32'(ferr_seen), 32'(vecs[k].exp_ferr));
      check($sformatf("vec%0d pops", k), 32'(pops), 32'(vecs[k].exp_pops));
    end

    // Back-to-back burst into a FIFO nobody drains: fifth byte overruns.
    ready = 1'b0;
    foreach (burst[k]) send_frame(burst[k], 1'b1, 1'b1, int'(NBITS * CPB));
    idle(8);
    check("burst overrun", 32'(ovr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d rxData", k), 32'(data), 32'(drain_exp[k]));
      ready = 1'b1;
      tick();
      ready = 1'b0;
    end
    idle(2);
    check("drained rxValid", 32'(valid), 32'd0);
    check("overrun sticky", 32'(ovr), 32'd1);

    // Short low glitch: receiver leaves IDLE, rejects at mid-start, pushes nothing.
    s = pops;
    rx = 1'b0;
    idle(4);
    check("glitch rxBusy high", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(20);
    check("glitch rxBusy low", 32'(busy), 32'd0);
    check("glitch no push", 32'(valid), 32'd0);

    // Reset during the 4th data bit of 0xC3, then a clean 0x96.
    ready = 1'b1;
    send_frame(8'hC3, 1'b1, 1'b1, int'(4 * CPB + CPB / 2));
    check("midframe rxBusy", 32'(busy), 32'd1);
    do_reset(8);
    idle(20);
    check("post-reset rxBusy", 32'(busy), 32'd0);
    pops = 0;
    send_frame(8'h96, 1'b1, 1'b1, int'(NBITS * CPB));
    idle(8);
    check("post-reset pops", 32'(pops), 32'd1);
    check("post-reset overrun", 32'(ovr), 32'd0);

    // Random frames with random consumer back-pressure.
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rp = ($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 1));
      send_frame(rb, rs, rp, int'(NBITS * CPB));
      idle_rand(int'(rs ? $urandom_range(0, 20) : $urandom_range(6, 24)));
    end
    ready = 1'b1;
    idle(10);
    check("final drain rxValid", 32'(valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 The block SHALL derive the local constant CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), default 868; legal values are 4 and above.
REQ-004 The block SHALL have ports clk, uartRxRst, uartRx, rxReady, rxData, rxValid, frameErr, overrun and rxBusy, as defined in REQ-005 to REQ-013.
REQ-005 clk  input  1  the single system clock; all logic is on the rising edge.
REQ-006 uartRxRst  input  1  asynchronous, active-high reset.
REQ-007 uartRx  input  1  asynchronous serial line; 8N1 frame; idles high.
REQ-008 rxReady  input  1  consumer accepts the head byte this cycle.
REQ-009 rxData  output  8  head byte of the receive FIFO; valid when rxValid is 1.
REQ-010 rxValid  output  1  receive FIFO is not empty.
REQ-011 frameErr  output  1  one-cycle pulse when a stop bit samples 0.
REQ-012 overrun  output  1  sticky flag: a received byte was dropped because the FIFO was full.
REQ-013 rxBusy  output  1  high in every receive state other than IDLE.

Function
REQ-014 uartRx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all further logic uses only the synchronized signal rxS.
REQ-015 The receiver SHALL implement the states IDLE, START, DATA, PARITY and STOP, plus ERRWAIT.
REQ-016 In IDLE, a 1-to-0 transition on rxS SHALL move the receiver to START and clear the bit counter.
REQ-017 In START, rxS SHALL be sampled after CLKS_PER_BIT/2 cycles; if it is 1 (a glitch), the receiver SHALL return to IDLE; if it is 0, it SHALL move to DATA.
REQ-018 In DATA, 8 bits SHALL be sampled LSB first, one every CLKS_PER_BIT cycles after the mid-start sample.
REQ-019 After the 8th data bit, the receiver SHALL go to STOP, or to PARITY when the parity feature is compiled in (see REQ-029).
REQ-020 STOP SHALL be sampled CLKS_PER_BIT cycles after the last data or parity bit. If it samples 1: push the byte into the FIFO and go to IDLE in the same cycle. If it samples 0: pulse frameErr for 1 cycle, discard the byte and go to ERRWAIT.
REQ-021 ERRWAIT SHALL return to IDLE on the first cycle in which rxS is 1.
REQ-022 The FIFO SHALL have 4 entries with 2-bit read/write pointers that wrap 3 to 0, and a 3-bit count.
REQ-023 rxData SHALL be the FIFO head, read combinationally; a pop SHALL occur on a cycle where rxValid and rxReady are both 1.
REQ-024 A push SHALL be accepted when count < 4, or when count == 4 and a pop occurs in the same cycle; simultaneous push and pop SHALL leave count unchanged.
REQ-025 A push attempted when count == 4 with no pop SHALL drop the byte and set overrun; overrun SHALL clear only on reset.
REQ-026 Latency SHALL be: rxValid rises on the cycle after the mid-stop sample; total latency from the falling edge on uartRx is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (8N1).

Reset
REQ-027 While uartRxRst is 1, the block SHALL hold state IDLE, both synchronizer flops at 1, FIFO count 0, pointers 0, rxData 0, rxValid 0, frameErr 0, overrun 0, rxBusy 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push and no frameErr; after release, the receiver SHALL wait in IDLE for a fresh falling edge.

Configuration
REQ-029 When macro UART_RX_PARITY_EN is defined, the frame SHALL be 8E1: the PARITY state samples one bit after data; a bit not equal to the XOR of the data bits SHALL be treated like a bad stop bit (frameErr pulse, byte discarded, then ERRWAIT after the stop slot). When the macro is undefined, the PARITY state SHALL be absent and the frame SHALL be 8N1.

Verification
Benches SHALL use CLK_FREQ=1600000 and BAUD=100000, giving CLKS_PER_BIT=16.
REQ-030 Send byte 0xA5 as 8N1 with rxReady=1 -> rxValid high 1 cycle with rxData=0xA5; frameErr=0; overrun=0.
REQ-031 Send 0x00, 0xFF, 0x3C, 0x81, 0x7E back-to-back with rxReady=0 -> first four bytes held in order; overrun=1; then popping 4 times yields 0x00, 0xFF, 0x3C, 0x81.
REQ-032 Send 0x55 with the stop bit forced 0 -> frameErr pulses once; rxValid stays 0; the next 0x12 is received correctly once the line returns high.
REQ-033 Hold uartRx low for 4 cycles, then high -> receiver returns to IDLE; no push; rxBusy falls.
REQ-034 Assert uartRxRst during the 4th data bit of 0xC3 -> all outputs reach their reset values; the following 0x96 is received intact.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 1 -> accepted; send 0x07 with parity bit 0 -> frameErr pulse and no push.
